// File: rtl/tof_phase_pkg.sv
// tof_phase_pkg: phase constants, FSM encoding and the CORDIC atan table shared by the ToF phase blocks.
package tof_phase_pkg;

    localparam int  PHASE_STEPS = 400;
    localparam int  HALF_TURN   = 200;
    localparam int  PHASE_W     = 9;
    localparam real CORDIC_GAIN = 1.6467602581210656;

    typedef enum logic [1:0] {IDLE, ROTATE, ROUND, DONE} state_t;

    // atan(1/d) as a 2^-96 fixed-point Taylor sum; only used at elaboration
    function automatic logic [127:0] atan_recip(input logic [127:0] d);
        logic [127:0] p, s;
        s = '0;
        p = (128'd1 << 96) / d;
        for (int n = 0; n < 48; n++) begin
            s = n[0] ? s - p / 128'(2 * n + 1) : s + p / 128'(2 * n + 1);
            p = p / (d * d);
        end
        return s;
    endfunction

    // round(atan(2^-k) * 400/(2*pi) * 2^frac), using pi/4 from Machin's formula
    function automatic logic [31:0] atan_step(input int k, input int frac);
        logic [127:0] q;
        q = 4 * atan_recip(128'd5) - atan_recip(128'd239);
        return k == 0 ? 32'(50) << frac
                      : 32'(((128'(50) << frac) * atan_recip(128'd1 << k) + q / 2) / q);
    endfunction

endpackage

// File: rtl/iq_to_phase.sv
// iq_to_phase: iterative vectoring CORDIC turning a signed I/Q pair into a
// 0..399 phase (1/400 turn) and an uncompensated magnitude.
module iq_to_phase
    import tof_phase_pkg::*;
#(
    parameter int W    = 48,
    parameter int ITER = 24,
    parameter int FRAC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_i,
    input  logic signed [W-1:0] in_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PHASE_W-1:0]  out_phase,
    output logic [W:0]          out_mag
);

    localparam int XW = W + 2;
    localparam int ZW = PHASE_W + FRAC + 2;
    localparam int PW = PHASE_W + 2;
    localparam int KW = $clog2(ITER + 1);

    state_t               state, state_nxt;
    logic signed [XW-1:0] x, y, ext_i, ext_q;
    logic signed [ZW-1:0] z;
    logic signed [PW-1:0] ph_raw;
    logic [PHASE_W-1:0]   ph_wrap;
    logic [KW-1:0]        k;
    logic                 zero;
    logic signed [ZW-1:0] atan_lut [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam logic signed [ZW-1:0] A = ZW'(atan_step(g, FRAC));
        assign atan_lut[g] = A;
    end

    assign ext_i   = XW'(in_i);
    assign ext_q   = XW'(in_q);
    assign ph_raw  = PW'((z + (ZW'(1) <<< (FRAC - 1))) >>> FRAC);
    assign ph_wrap = PHASE_W'(ph_raw < 0 ? ph_raw + PW'(PHASE_STEPS)
                            : ph_raw >= PW'(PHASE_STEPS) ? ph_raw - PW'(PHASE_STEPS) : ph_raw);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (in_valid) state_nxt = ROTATE;
            ROTATE: if (k == KW'(ITER - 1)) state_nxt = ROUND;
            ROUND:  state_nxt = DONE;
            DONE:   if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // Left half-plane inputs are turned by 180 degrees first so the micro-rotations converge.
    // A zero vector has no angle; the flag forces phase 0 instead of the summed table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            k         <= '0;
            zero      <= 1'b0;
            out_phase <= '0;
            out_mag   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x    <= in_i[W-1] ? -ext_i : ext_i;
                    y    <= in_i[W-1] ? -ext_q : ext_q;
                    z    <= in_i[W-1] ? ZW'(HALF_TURN) <<< FRAC : '0;
                    k    <= '0;
                    zero <= in_i == '0 && in_q == '0;
                end
                ROTATE: begin
                    x <= y[XW-1] ? x - (y >>> k) : x + (y >>> k);
                    y <= y[XW-1] ? y + (x >>> k) : y - (x >>> k);
                    z <= y[XW-1] ? z - atan_lut[k] : z + atan_lut[k];
                    k <= k + 1'b1;
                end
                ROUND: begin
                    out_phase <= zero ? '0 : ph_wrap;
                    out_mag   <= x[W:0];
                end
                default: ;
            endcase
        end
    end

endmodule
